// File: rtl/shift_subtract_divide_if.sv
// Start/ready handshake and operand/result bus for the restoring divider.
// Latency: none (wires only).
// Backpressure: the requester may only start while ready is high; there is no other flow control.
//
// Signals:
//   start       requester -> divider, sampled only while ready=1
//   dividend    requester -> divider, 2*WIDTH-bit unsigned numerator
//   divisor     requester -> divider, WIDTH-bit unsigned denominator
//   quotient    divider -> requester, 2*WIDTH-bit registered result
//   remainder   divider -> requester, WIDTH-bit registered result
//   ready       divider -> requester, idle/done (1) or busy (0)
//   div_by_zero divider -> requester, flag for the last completed operation
interface shift_subtract_divide_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 ready;
    logic                 div_by_zero;

    // Requester side.
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, div_by_zero
    );
endinterface

// File: rtl/shift_subtract_divide.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Latency: ready low for exactly 2*WIDTH cycles after the accepting edge; divide-by-zero completes on the accepting edge.
// Backpressure: start is only accepted while ready=1; start during BUSY is dropped, not queued.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, aborts any operation in flight
//   bus  slave side of shift_subtract_divide_if (start/dividend/divisor in,
//        quotient/remainder/ready/div_by_zero out, all outputs registered)
module shift_subtract_divide #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_subtract_divide_if.slave bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    // Dividend shifts out at the MSB while quotient bits shift in at the LSB,
    // so after 2*WIDTH steps this register holds the finished quotient.
    logic [DW-1:0]   dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [DW-1:0]   quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic            ready_q;
    logic            dbz_q;

    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_d;
    logic [DW-1:0]    dvd_d;

    // One restoring step. The partial remainder is kept at WIDTH bits between
    // steps because it is always < divisor; the extra bit only exists in the
    // shifted value. When rem_ge is set the true difference is < divisor, so
    // the WIDTH-bit modular subtraction is exact.
    always_comb begin
        rem_shift = {rem_q, dvd_q[DW-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
        rem_d     = rem_shift[WIDTH-1:0];
        if (rem_ge) begin
            rem_d = rem_sub;
        end
        dvd_d     = {dvd_q[DW-2:0], rem_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b1;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvd_q   <= bus.dividend;
                        dvs_q   <= bus.divisor;
                        rem_q   <= '0;
                        count_q <= '0;
                        dbz_q   <= 1'b0;
                        if (bus.divisor != '0) begin
                            state_q <= BUSY;
                            ready_q <= 1'b0;
                        end else begin
                            // Zero divisor finishes immediately; ready never drops.
                            state_q     <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend[WIDTH-1:0];
                            dbz_q       <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    dvd_q   <= dvd_d;
                    rem_q   <= rem_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST_STEP) begin
                        state_q     <= DONE;
                        ready_q     <= 1'b1;
                        quotient_q  <= dvd_d;
                        remainder_q <= rem_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.ready       = ready_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_subtract_divide.sv
// Directed self-checking bench for shift_subtract_divide.
// Latency: checks ready-low window of 2*WIDTH cycles per divide.
// Backpressure: exercises start during BUSY and back-to-back start held high.
module tb_shift_subtract_divide;
    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;

    shift_subtract_divide_if #(.WIDTH(WIDTH)) bus ();

    shift_subtract_divide #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until ready returns; bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.ready && n < 100);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;

        // Reset
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_quot", 64'(bus.quotient), 64'd0);
        check("rst_rem", 64'(bus.remainder), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);

        // Basic 100000 / 7
        bus.dividend = 32'd100000;
        bus.divisor = 16'd7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("basic_busy", 64'(bus.ready), 64'd0);
        repeat (10) step();
        check("basic_hold_quot_busy", 64'(bus.quotient), 64'd0);
        wait_done(lat);
        check("basic_lat", 64'(lat), 64'd22);
        check("basic_quot", 64'(bus.quotient), 64'd14285);
        check("basic_rem", 64'(bus.remainder), 64'd5);
        check("basic_dbz", 64'(bus.div_by_zero), 64'd0);
        repeat (20) step();
        check("basic_hold_ready", 64'(bus.ready), 64'd1);
        check("basic_hold_quot", 64'(bus.quotient), 64'd14285);
        check("basic_hold_rem", 64'(bus.remainder), 64'd5);

        // Back-to-back boundaries, start held high
        bus.dividend = 32'hFFFF_FFFF;
        bus.divisor = 16'hFFFF;
        bus.start = 1'b1;
        step();
        bus.dividend = 32'hFFFF_FFFF;
        bus.divisor = 16'd1;
        wait_done(lat);
        check("b2b1_lat", 64'(lat), 64'd32);
        check("b2b1_quot", 64'(bus.quotient), 64'h0001_0001);
        check("b2b1_rem", 64'(bus.remainder), 64'd0);
        step();
        check("b2b2_accept", 64'(bus.ready), 64'd0);
        bus.dividend = 32'd5;
        bus.divisor = 16'd9;
        wait_done(lat);
        check("b2b2_lat", 64'(lat + 1), 64'd33);
        check("b2b2_quot", 64'(bus.quotient), 64'hFFFF_FFFF);
        check("b2b2_rem", 64'(bus.remainder), 64'd0);
        step();
        bus.start = 1'b0;
        wait_done(lat);
        check("b2b3_lat", 64'(lat + 1), 64'd33);
        check("b2b3_quot", 64'(bus.quotient), 64'd0);
        check("b2b3_rem", 64'(bus.remainder), 64'd5);
        step();
        check("b2b3_idle", 64'(bus.ready), 64'd1);

        // Divide by zero, then a normal divide clears the flag
        bus.dividend = 32'd1234;
        bus.divisor = 16'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("dbz_ready", 64'(bus.ready), 64'd1);
        check("dbz_quot", 64'(bus.quotient), 64'hFFFF_FFFF);
        check("dbz_rem", 64'(bus.remainder), 64'h04D2);
        check("dbz_flag", 64'(bus.div_by_zero), 64'd1);
        bus.dividend = 32'd10;
        bus.divisor = 16'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("dbz_clear", 64'(bus.div_by_zero), 64'd0);
        wait_done(lat);
        check("after_dbz_lat", 64'(lat), 64'd32);
        check("after_dbz_quot", 64'(bus.quotient), 64'd3);
        check("after_dbz_rem", 64'(bus.remainder), 64'd1);

        // Start during BUSY is ignored
        bus.dividend = 32'd1000;
        bus.divisor = 16'd10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.dividend = 32'd77;
        bus.divisor = 16'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(lat);
        check("busy_lat", 64'(lat + 5), 64'd32);
        check("busy_quot", 64'(bus.quotient), 64'd100);
        check("busy_rem", 64'(bus.remainder), 64'd0);

        // Reset mid-operation, asynchronous
        bus.dividend = 32'h1234_5678;
        bus.divisor = 16'h1234;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (15) step();
        check("mid_busy", 64'(bus.ready), 64'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(bus.ready), 64'd1);
        check("mid_rst_quot", 64'(bus.quotient), 64'd0);
        check("mid_rst_rem", 64'(bus.remainder), 64'd0);
        check("mid_rst_dbz", 64'(bus.div_by_zero), 64'd0);
        step();
        rst = 1'b0;
        step();
        bus.dividend = 32'd50;
        bus.divisor = 16'd6;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(lat);
        check("post_rst_lat", 64'(lat), 64'd32);
        check("post_rst_quot", 64'(bus.quotient), 64'd8);
        check("post_rst_rem", 64'(bus.remainder), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
